// File: rtl/burst_read_master_if.sv
// Burst read bus between burst_read_master and the memory slave it drains.
interface burst_read_master_if #(
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int ADDRESSWIDTH    = 32,
    parameter int BURSTCOUNTWIDTH = 3
);
    logic [ADDRESSWIDTH-1:0]    master_address;
    logic                       master_read;
    logic [BURSTCOUNTWIDTH-1:0] master_burstcount;
    logic [BYTEENABLEWIDTH-1:0] master_byteenable;
    logic [DATAWIDTH-1:0]       master_readdata;
    logic                       master_readdatavalid;
    logic                       master_waitrequest;

    modport master (
        output master_address, master_read, master_burstcount, master_byteenable,
        input  master_readdata, master_readdatavalid, master_waitrequest
    );

    modport slave (
        input  master_address, master_read, master_burstcount, master_byteenable,
        output master_readdata, master_readdatavalid, master_waitrequest
    );
endinterface

// File: rtl/burst_read_master.sv
// Burst read master: posts bursts only when the show-ahead FIFO has room reserved
// for every outstanding word, and hands returned data to the user in order.
module burst_read_master #(
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int ADDRESSWIDTH    = 32,
    parameter int MAXBURSTCOUNT   = 4,
    parameter int BURSTCOUNTWIDTH = 3,
    parameter int FIFODEPTH       = 32,
    parameter int FIFODEPTH_LOG2  = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0] control_read_base,
    input  logic [ADDRESSWIDTH-1:0] control_read_length,
    input  logic                    control_go,
    output logic                    control_done,
    output logic                    control_early_done,
    input  logic                    user_read_buffer,
    output logic [DATAWIDTH-1:0]    user_buffer_data,
    output logic                    user_data_available,
    burst_read_master_if.master     bus
);
    localparam int CW = FIFODEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [ADDRESSWIDTH-1:0]    address;
    logic [ADDRESSWIDTH-1:0]    words;
    logic [ADDRESSWIDTH-1:0]    words_load;
    logic                       fixed;
    logic                       read_q;
    logic [BURSTCOUNTWIDTH-1:0] burstcount_q;
    logic [BURSTCOUNTWIDTH-1:0] burst;
    logic [CW-1:0]              reads_pending;
    logic [CW-1:0]              fifo_used;
    logic [CW-1:0]              space;
    logic                       go_accept;
    logic                       accept;
    logic                       rdv_accept;
    logic                       push;
    logic                       pop;
    logic [FIFODEPTH_LOG2-1:0]  wr_ptr;
    logic [FIFODEPTH_LOG2-1:0]  rd_ptr;
    logic [DATAWIDTH-1:0]       mem [FIFODEPTH];

    assign words_load = control_read_length / ADDRESSWIDTH'(BYTEENABLEWIDTH);
    assign go_accept  = control_go && (state == IDLE);
    assign accept     = read_q && !bus.master_waitrequest;
    // Returns seen while idle belong to a transfer killed by reset.
    assign rdv_accept = bus.master_readdatavalid && (state != IDLE);

    assign burst = (words >= ADDRESSWIDTH'(MAXBURSTCOUNT)) ? BURSTCOUNTWIDTH'(MAXBURSTCOUNT)
                                                            : words[BURSTCOUNTWIDTH-1:0];
    assign space = CW'(FIFODEPTH) - fifo_used - reads_pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (control_go && (words_load != '0)) state_next = ISSUE;
            ISSUE:   if (words == '0) state_next = DRAIN;
            DRAIN:   if (reads_pending == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address       <= '0;
            words         <= '0;
            fixed         <= 1'b0;
            read_q        <= 1'b0;
            burstcount_q  <= '0;
            reads_pending <= '0;
        end else begin
            if (go_accept) begin
                address <= control_read_base;
                words   <= words_load;
                fixed   <= control_fixed_location;
            end else if (accept) begin
                words <= words - ADDRESSWIDTH'(burstcount_q);
                if (!fixed) begin
                    address <= address + ADDRESSWIDTH'(burstcount_q) * ADDRESSWIDTH'(BYTEENABLEWIDTH);
                end
            end

            // After an accept read drops for a cycle so space is re-checked with updated counts.
            if (read_q && bus.master_waitrequest) begin
                read_q <= 1'b1;
            end else if (accept) begin
                read_q <= 1'b0;
            end else if ((state == ISSUE) && (words != '0) && (space >= CW'(burst))) begin
                read_q       <= 1'b1;
                burstcount_q <= burst;
            end

            reads_pending <= reads_pending
                           + (accept ? CW'(burstcount_q) : CW'(0))
                           - (rdv_accept ? CW'(1) : CW'(0));
        end
    end

    assign pop  = user_read_buffer && (fifo_used != '0);
    assign push = rdv_accept && ((fifo_used != CW'(FIFODEPTH)) || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_used <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFODEPTH_LOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFODEPTH_LOG2'(1);
            fifo_used <= fifo_used + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.master_readdata;
    end

    assign user_buffer_data      = mem[rd_ptr];
    assign user_data_available   = (fifo_used != '0);
    assign control_done          = (state == IDLE);
    assign control_early_done    = (words == '0);
    assign bus.master_address    = address;
    assign bus.master_read       = read_q;
    assign bus.master_burstcount = burstcount_q;
    assign bus.master_byteenable = '1;
endmodule

// File: doc/burst_read_master.md
BURST_READ_MASTER -- requirements
Module: burst_read_master

Interface
REQ-001 SHALL provide parameter DATAWIDTH, default 32, read data width in bits.
REQ-002 SHALL provide parameter BYTEENABLEWIDTH, default 4, bytes per word (DATAWIDTH/8).
REQ-003 SHALL provide parameter ADDRESSWIDTH, default 32, byte address and length width.
REQ-004 SHALL provide parameter MAXBURSTCOUNT, default 4, largest burst in words (power of 2, >=1).
REQ-005 SHALL provide parameter BURSTCOUNTWIDTH, default 3, log2(MAXBURSTCOUNT)+1.
REQ-006 SHALL provide parameter FIFODEPTH, default 32, buffer words (power of 2, >= 2*MAXBURSTCOUNT).
REQ-007 SHALL provide parameter FIFODEPTH_LOG2, default 5, log2(FIFODEPTH).
REQ-008 SHALL have ports: clk in 1 system clock; reset_n in 1 asynchronous active-low reset.
REQ-009 SHALL have ports: control_fixed_location in 1 hold address constant; control_read_base in ADDRESSWIDTH word-aligned start; control_read_length in ADDRESSWIDTH byte count; control_go in 1 start pulse.
REQ-010 SHALL have ports: control_done out 1 idle, all data returned; control_early_done out 1 all bursts posted.
REQ-011 SHALL have ports: user_read_buffer in 1 pop; user_buffer_data out DATAWIDTH FIFO head; user_data_available out 1 FIFO not empty.
REQ-012 SHALL have ports: master_address out ADDRESSWIDTH; master_read out 1; master_burstcount out BURSTCOUNTWIDTH; master_byteenable out BYTEENABLEWIDTH; master_readdata in DATAWIDTH; master_readdatavalid in 1; master_waitrequest in 1.

Function
REQ-013 SHALL run in the clk domain only; the FIFO is single-clock, show-ahead, FIFODEPTH words.
REQ-014 SHALL accept control_go only while control_done=1; control_go while busy is ignored.
REQ-015 SHALL on accepted go load address=control_read_base, words=control_read_length/BYTEENABLEWIDTH (low bits discarded), latch control_fixed_location.
REQ-016 SHALL implement states IDLE, ISSUE, DRAIN: IDLE->ISSUE on go with words!=0; ISSUE->DRAIN when words reaches 0; DRAIN->IDLE when reads_pending=0.
REQ-017 SHALL in IDLE with go and words=0 remain IDLE, control_done held 1.
REQ-018 SHALL compute burst = min(MAXBURSTCOUNT, words) and assert master_read (registered) only when FIFODEPTH - fifo_used - reads_pending >= burst.
REQ-019 SHALL hold master_address, master_burstcount and master_read stable while master_read=1 and master_waitrequest=1.
REQ-020 SHALL on accept (master_read=1, master_waitrequest=0) decrement words by burst, add burst to reads_pending, and add burst*BYTEENABLEWIDTH to address unless fixed location latched.
REQ-021 SHALL deassert master_read the cycle after accept and re-evaluate space before the next burst (minimum one idle cycle between bursts).
REQ-022 SHALL decrement reads_pending by 1 per master_readdatavalid; simultaneous accept and return net to reads_pending + burst - 1.
REQ-023 SHALL write master_readdata into the FIFO on every master_readdatavalid; reservation guarantees no overflow.
REQ-024 SHALL drive master_byteenable all ones.
REQ-025 SHALL present a written word on user_buffer_data with user_data_available=1 the cycle after its readdatavalid.
REQ-026 SHALL ignore user_read_buffer when FIFO empty; simultaneous push and pop on a full or empty FIFO SHALL keep count consistent.
REQ-027 SHALL drive control_early_done = (words=0), control_done = (state=IDLE).
REQ-028 SHALL first assert master_read no earlier than the cycle after the accepted go.

Reset
REQ-029 SHALL on reset_n=0, asynchronously: state IDLE, address 0, words 0, reads_pending 0, FIFO empty, master_read 0, master_burstcount 0, control_done 1, control_early_done 1, user_data_available 0.
REQ-030 SHALL on reset mid-transfer discard all pending reads and FIFO contents; readdatavalid arriving after reset release while IDLE SHALL be dropped.

Verification
REQ-031 go, base 0x1000, length 40, zero-latency slave -> bursts 4,4,2 at 0x1000,0x1010,0x1020; 10 words in order; control_done 1 after last word.
REQ-032 length 16, fixed_location=1 -> four-word burst at base only; subsequent 4-word run repeats same address.
REQ-033 user never pops, length 256 -> master_read stalls with fifo_used+reads_pending <= 32; no overflow; resumes on pops.
REQ-034 waitrequest held 5 cycles on first burst -> address/burstcount/read stable all 5 cycles; single accept.
REQ-035 length 0 or 3 -> no master_read; control_done stays 1.
REQ-036 reset_n low mid-burst then go -> all REQ-029 values; new transfer starts clean, stale readdatavalid ignored.
